// File: rtl/isp_raw_tpg_if.sv
// Raw Bayer video stream produced by isp_raw_tpg and consumed by isp_bnr-style blocks.
interface isp_raw_tpg_if #(
    parameter int BITS = 8
);
    logic            out_href;
    logic            out_vsync;
    logic            out_de;
    logic [BITS-1:0] out_raw;

    modport master (output out_href, output out_vsync, output out_de, output out_raw);
    modport slave  (input  out_href, input  out_vsync, input  out_de, input  out_raw);
endinterface

// File: rtl/isp_raw_tpg.sv
// Raw Bayer test pattern generator: frame timing FSM plus pattern synthesis
// (flat, ramps, colour bars, checkerboard) with fully registered outputs.
module isp_raw_tpg #(
    parameter int BITS        = 8,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int BAYER       = 0,
    parameter int H_BLANK     = 160,
    parameter int VSYNC_LINES = 2,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 8
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [2:0]      mode,
    input  logic [BITS-1:0] level,
    isp_raw_tpg_if.master   vid,
    output logic            frame_done,
    output logic [7:0]      frame_cnt
);

    localparam int LINE      = WIDTH + H_BLANK;
    localparam int M1        = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int M2        = (HEIGHT > V_FRONT) ? HEIGHT : V_FRONT;
    localparam int MAX_LINES = (M1 > M2) ? M1 : M2;
    // Counters are at least 4 bits so the checkerboard can always use bit 3.
    localparam int HW        = ($clog2(LINE) < 4) ? 4 : $clog2(LINE);
    localparam int LW        = ($clog2(MAX_LINES) < 4) ? 4 : $clog2(MAX_LINES);
    localparam int BAR_W     = WIDTH / 8;
    localparam int PW        = ($clog2(BAR_W) < 1) ? 1 : $clog2(BAR_W);

    localparam logic [HW-1:0]   H_LAST   = HW'(LINE - 1);
    localparam logic [HW-1:0]   X_END    = HW'(WIDTH);
    localparam logic [LW-1:0]   VS_LAST  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0]   VB_LAST  = LW'(V_BACK - 1);
    localparam logic [LW-1:0]   ACT_LAST = LW'(HEIGHT - 1);
    localparam logic [LW-1:0]   VF_LAST  = LW'(V_FRONT - 1);
    localparam logic [PW-1:0]   BAR_LAST = PW'(BAR_W - 1);
    localparam logic [1:0]      CFA      = 2'(BAYER);
    localparam logic [BITS-1:0] ONES     = {BITS{1'b1}};
    localparam logic [BITS-1:0] ZERO     = {BITS{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [HW-1:0]   hcnt_r;
    logic [LW-1:0]   lcnt_r;
    logic [PW-1:0]   bar_pos_r;
    logic [2:0]      bar_r;
    logic [2:0]      mode_r;
    logic [BITS-1:0] level_r;

    logic            line_end_s, last_line_s, frame_end_s, start_s;
    logic            active_s, bar_on_s;
    logic [1:0]      fmt_s;
    logic [BITS-1:0] pix_s;

    assign line_end_s  = (hcnt_r == H_LAST);
    assign frame_end_s = (state_r == ST_VFRONT) && line_end_s && last_line_s;
    assign start_s     = ((state_r == ST_IDLE) || frame_end_s) && en;

    // Last line of the current vertical region.
    always_comb begin
        case (state_r)
            ST_VSYNC:  last_line_s = (lcnt_r == VS_LAST);
            ST_VBACK:  last_line_s = (lcnt_r == VB_LAST);
            ST_ACTIVE: last_line_s = (lcnt_r == ACT_LAST);
            ST_VFRONT: last_line_s = (lcnt_r == VF_LAST);
            default:   last_line_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; regions advance only at the end of their last line.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) state_s = ST_VSYNC;
                else    state_s = ST_IDLE;
            end
            ST_VSYNC: begin
                if (line_end_s && last_line_s) state_s = ST_VBACK;
                else                           state_s = ST_VSYNC;
            end
            ST_VBACK: begin
                if (line_end_s && last_line_s) state_s = ST_ACTIVE;
                else                           state_s = ST_VBACK;
            end
            ST_ACTIVE: begin
                if (line_end_s && last_line_s) state_s = ST_VFRONT;
                else                           state_s = ST_ACTIVE;
            end
            ST_VFRONT: begin
                if (line_end_s && last_line_s) state_s = en ? ST_VSYNC : ST_IDLE;
                else                           state_s = ST_VFRONT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Pixel/line counters, bar tracker, per-frame settings and frame counter.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r    <= {HW{1'b0}};
            lcnt_r    <= {LW{1'b0}};
            bar_pos_r <= {PW{1'b0}};
            bar_r     <= 3'd0;
            mode_r    <= 3'd0;
            level_r   <= ZERO;
            frame_cnt <= 8'd0;
        end else begin
            if (state_r == ST_IDLE) begin
                hcnt_r <= {HW{1'b0}};
                lcnt_r <= {LW{1'b0}};
            end else if (line_end_s) begin
                hcnt_r <= {HW{1'b0}};
                lcnt_r <= last_line_s ? {LW{1'b0}} : lcnt_r + {{(LW-1){1'b0}}, 1'b1};
            end else begin
                hcnt_r <= hcnt_r + {{(HW-1){1'b0}}, 1'b1};
            end
            // Bar index tracks hcnt / (WIDTH/8) incrementally instead of dividing.
            if ((state_r == ST_IDLE) || line_end_s) begin
                bar_pos_r <= {PW{1'b0}};
                bar_r     <= 3'd0;
            end else if (bar_pos_r == BAR_LAST) begin
                bar_pos_r <= {PW{1'b0}};
                bar_r     <= bar_r + 3'd1;
            end else begin
                bar_pos_r <= bar_pos_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (start_s) begin
                mode_r  <= mode;
                level_r <= level;
            end
            if (frame_end_s) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Output decode: pixel value for the current counter position.
    always_comb begin
        active_s = (state_r == ST_ACTIVE) && (hcnt_r < X_END);
        fmt_s    = CFA ^ {lcnt_r[0], hcnt_r[0]};
        case (fmt_s)
            2'd0:    bar_on_s = bar_r[2];
            2'd3:    bar_on_s = bar_r[0];
            default: bar_on_s = bar_r[1];
        endcase
        case (mode_r)
            3'd1:    pix_s = BITS'(hcnt_r);
            3'd2:    pix_s = bar_on_s ? ONES : ZERO;
            3'd3:    pix_s = (hcnt_r[3] ^ lcnt_r[3]) ? ONES : ZERO;
            3'd4:    pix_s = BITS'(hcnt_r) + BITS'(frame_cnt);
            default: pix_s = level_r;
        endcase
    end

    // Registered video outputs and frame-done pulse.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vid.out_vsync <= 1'b0;
            vid.out_href  <= 1'b0;
            vid.out_de    <= 1'b0;
            vid.out_raw   <= ZERO;
            frame_done    <= 1'b0;
        end else begin
            vid.out_vsync <= (state_r == ST_VSYNC);
            vid.out_href  <= active_s;
            vid.out_de    <= active_s;
            vid.out_raw   <= active_s ? pix_s : ZERO;
            frame_done    <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_isp_raw_tpg.sv
// Bench for isp_raw_tpg: two small configurations against a frame-position model
// plus directed literal checks at hand-computed edges.
module tb_isp_raw_tpg;

    logic       pclk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] level;
    logic       fd8, fd16;
    logic [7:0] fc8, fc16;

    isp_raw_tpg_if #(.BITS(8)) v8 ();
    isp_raw_tpg_if #(.BITS(8)) v16 ();

    isp_raw_tpg #(.BITS(8), .WIDTH(8), .HEIGHT(4), .BAYER(1), .H_BLANK(4),
                  .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut8 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .mode(mode), .level(level),
        .vid(v8), .frame_done(fd8), .frame_cnt(fc8));

    isp_raw_tpg #(.BITS(8), .WIDTH(16), .HEIGHT(4), .BAYER(0), .H_BLANK(4),
                  .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut16 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .mode(mode), .level(level),
        .vid(v16), .frame_done(fd16), .frame_cnt(fc16));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_fail = 0;
    int ec     = 0;
    int t0     = 0;
    bit chk_en = 1'b0;
    int fdc8   = 0;
    int fdc16  = 0;

    always @(posedge pclk) ec <= ec + 1;

    function automatic int wid(input int k);
        return (k == 0) ? 8 : 16;
    endfunction
    function automatic int bay(input int k);
        return (k == 0) ? 1 : 0;
    endfunction
    function automatic int lin(input int k);
        return wid(k) + 4;
    endfunction

    // Pattern value from the pattern rules, using plain arithmetic.
    function automatic int exp_pix(input int k, input int x, input int y,
                                   input int md, input int lv, input int fc);
        int fmt, b, on;
        fmt = bay(k) ^ (((y % 2) << 1) | (x % 2));
        case (md)
            1: return x % 256;
            2: begin
                b  = x / (wid(k) / 8);
                on = (fmt == 0) ? ((b >> 2) & 1) : (fmt == 3) ? (b & 1) : ((b >> 1) & 1);
                return (on != 0) ? 255 : 0;
            end
            3: return (((x / 8) ^ (y / 8)) % 2 != 0) ? 255 : 0;
            4: return (x + fc) % 256;
            default: return lv;
        endcase
    endfunction

    // Model: a frame is 7 lines (vsync, back porch, 4 active, front porch).
    bit m_busy [2];
    int m_pos  [2];
    int m_mode [2];
    int m_lvl  [2];
    int m_fc   [2];
    int e_vs   [2];
    int e_hr   [2];
    int e_raw  [2];
    int e_fd   [2];
    int e_fc   [2];

    always @(posedge pclk or negedge rst_n) begin
        int ln, x, frame;
        bit vs, act, fd;
        int raw;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] <= 1'b0; m_pos[k] <= 0; m_mode[k] <= 0; m_lvl[k] <= 0; m_fc[k] <= 0;
                e_vs[k] <= 0; e_hr[k] <= 0; e_raw[k] <= 0; e_fd[k] <= 0; e_fc[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                frame = 7 * lin(k);
                ln    = m_pos[k] / lin(k);
                x     = m_pos[k] % lin(k);
                vs    = m_busy[k] && (ln < 1);
                act   = m_busy[k] && (ln >= 2) && (ln < 6) && (x < wid(k));
                raw   = act ? exp_pix(k, x, ln - 2, m_mode[k], m_lvl[k], m_fc[k]) : 0;
                fd    = m_busy[k] && (m_pos[k] == frame - 1);
                e_vs[k]  <= vs ? 1 : 0;
                e_hr[k]  <= act ? 1 : 0;
                e_raw[k] <= raw;
                e_fd[k]  <= fd ? 1 : 0;
                e_fc[k]  <= fd ? (m_fc[k] + 1) % 256 : m_fc[k];
                if (!m_busy[k]) begin
                    if (en) begin
                        m_busy[k] <= 1'b1; m_pos[k] <= 0;
                        m_mode[k] <= int'(mode); m_lvl[k] <= int'(level);
                    end
                end else if (fd) begin
                    m_fc[k] <= (m_fc[k] + 1) % 256;
                    m_pos[k] <= 0;
                    if (en) begin
                        m_mode[k] <= int'(mode); m_lvl[k] <= int'(level);
                    end else begin
                        m_busy[k] <= 1'b0;
                    end
                end else begin
                    m_pos[k] <= m_pos[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, ec);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge pclk) begin
        if (chk_en) begin
            chk("d8.vsync", 32'(v8.out_vsync), e_vs[0]);
            chk("d8.href",  32'(v8.out_href),  e_hr[0]);
            chk("d8.de",    32'(v8.out_de),    e_hr[0]);
            chk("d8.raw",   32'(v8.out_raw),   e_raw[0]);
            chk("d8.fdone", 32'(fd8),          e_fd[0]);
            chk("d8.fcnt",  32'(fc8),          e_fc[0]);
            chk("d16.vsync", 32'(v16.out_vsync), e_vs[1]);
            chk("d16.href",  32'(v16.out_href),  e_hr[1]);
            chk("d16.de",    32'(v16.out_de),    e_hr[1]);
            chk("d16.raw",   32'(v16.out_raw),   e_raw[1]);
            chk("d16.fdone", 32'(fd16),          e_fd[1]);
            chk("d16.fcnt",  32'(fc16),          e_fc[1]);
            if (fd8 === 1'b1)  fdc8++;
            if (fd16 === 1'b1) fdc16++;
        end
    end

    // Advance to 2 time units after edge t0+n.
    task automatic at(input int n);
        while (ec < t0 + n) begin
            @(posedge pclk);
            #1;
        end
        #1;
    endtask

    task automatic chk_idle8(input string name, input int fc);
        chk({name, ".vsync"}, 32'(v8.out_vsync), 0);
        chk({name, ".href"},  32'(v8.out_href),  0);
        chk({name, ".raw"},   32'(v8.out_raw),   0);
        chk({name, ".fdone"}, 32'(fd8),          0);
        chk({name, ".fcnt"},  32'(fc8),          fc);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; en = 1'b0; mode = 3'd0; level = 8'd0;
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;
        #1 chk_idle8("reset", 0);
        chk_en = 1'b1;

        // Edge 0: en driven high, mode 1 ramp.
        @(posedge pclk); #1;
        t0 = ec; mode = 3'd1; level = 8'h5A; en = 1'b1;
        at(1);  chk("vs@1",  32'(v8.out_vsync), 0);
        at(2);  chk("vs@2",  32'(v8.out_vsync), 1);
        at(13); chk("vs@13", 32'(v8.out_vsync), 1);
        at(14); chk("vs@14", 32'(v8.out_vsync), 0);
        at(25); chk("href@25", 32'(v8.out_href), 0);
        at(26); chk("href@26", 32'(v8.out_href), 1); chk("raw@26", 32'(v8.out_raw), 0);
        at(27); chk("raw@27", 32'(v8.out_raw), 1);
        at(33); chk("raw@33", 32'(v8.out_raw), 7);
        at(34); chk("href@34", 32'(v8.out_href), 0); chk("raw@34", 32'(v8.out_raw), 0);
        at(38); chk("href@38", 32'(v8.out_href), 1);
        at(40); mode = 3'd2;
        at(84); chk("fd@84", 32'(fd8), 0);
        at(85); chk("fd@85", 32'(fd8), 1); chk("fc@85", 32'(fc8), 1);
        at(86); chk("fd@86", 32'(fd8), 0);

        // Colour bars on the 16-wide instance, frame 2, line y=0.
        at(150); mode = 3'd0; level = 8'h33;
        at(183); chk("bar x1",  32'(v16.out_raw), 0);
        at(187); chk("bar x5",  32'(v16.out_raw), 255);
        at(196); chk("bar x14", 32'(v16.out_raw), 255);

        // Mode switched mid-frame: current frame stays flat.
        at(200); mode = 3'd4;
        at(209); chk("flat held", 32'(v8.out_raw), 32'h33);
        at(283); chk("moving ramp", 32'(v8.out_raw), 8);

        // en dropped mid-frame: frames still complete.
        at(300); en = 1'b0;
        at(337); chk("d8 last fd", 32'(fd8), 1); chk("d8 last fc", 32'(fc8), 4);
        at(421); chk("d16 last fd", 32'(fd16), 1); chk("d16 last fc", 32'(fc16), 3);
        at(440);
        chk_idle8("idle", 4);
        chk("d16 idle href", 32'(v16.out_href), 0);
        chk("d8 fd pulses", 32'(fdc8), 4);
        chk("d16 fd pulses", 32'(fdc16), 3);

        // Reset during ACTIVE, then restart with en held high.
        t0 = ec; en = 1'b1;
        at(30); chk("pre-rst href", 32'(v8.out_href), 1);
        #1 rst_n = 1'b0;
        #1 chk_idle8("async rst", 0);
        at(32); rst_n = 1'b1;
        at(33); chk("rst vs@33", 32'(v8.out_vsync), 0);
        at(34); chk("rst vs@34", 32'(v8.out_vsync), 1);

        // Run to frame_cnt 255 and across the wrap.
        found = 1'b0;
        for (int i = 0; i < 260 * 84 && !found; i++) begin
            @(posedge pclk); #2;
            if (fc8 == 8'd255) found = 1'b1;
        end
        chk("reach 255", 32'(found), 1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge pclk); #2;
            if (fd8 === 1'b1) found = 1'b1;
        end
        chk("wrap fd", 32'(found), 1);
        chk("wrap fc", 32'(fc8), 0);
        en = 1'b0;
        repeat (200) @(posedge pclk);
        #2 chk_idle8("end idle", 32'(fc8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
